// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {INIT, RUN, MEMWAIT} pipe_state_t;
    localparam int WAIT_CNT_W = 8;
    typedef struct packed {
        logic en;
        logic clear;
    } stage_ctrl_t;
endpackage

// File: rtl/pipe_ctrl_load_use.sv
// load_use_detect: flags an ID source that depends on a load still in EX
module load_use_detect (
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       mem_read,
    output logic       hazard
);
    assign hazard = mem_read && rd != 5'd0 && (rd == rs1 || rd == rs2);
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline enable/clear sequencing; perf counters built only with PIPE_CTRL_PERF_EN
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdE,
    input  logic        MemReadE,
    input  logic        JumpD,
    input  logic        BranchTakenE,
    input  logic        ImemReadyF,
    input  logic        DmemReqM,
    input  logic        DmemReadyM,
    output logic        EnF,
    output logic        EnD,
    output logic        ClearD,
    output logic        EnE,
    output logic        ClearE,
    output logic        EnM,
    output logic        ClearW,
    output logic        RedirectOK,
    output logic        MemTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
);
    pipe_state_t           state, state_next;
    logic                  pend, pend_next, timeout_q, load_use, mem_stall;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_next;
    stage_ctrl_t           d, e;

    load_use_detect u_lud (
        .rs1      (Rs1D),
        .rs2      (Rs2D),
        .rd       (RdE),
        .mem_read (MemReadE),
        .hazard   (load_use)
    );

    assign mem_stall  = (state == MEMWAIT) ? !DmemReadyM : (state == RUN && DmemReqM && !DmemReadyM);
    assign MemTimeout = timeout_q || (state == MEMWAIT && wait_cnt == WAIT_CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            pend      <= 1'b0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            pend      <= pend_next;
            wait_cnt  <= wait_cnt_next;
            timeout_q <= MemTimeout;
        end
    end

    // a redirect seen while memory stalls is held until the stall resolves
    always_comb begin
        state_next    = (state == INIT) ? RUN : (mem_stall ? MEMWAIT : RUN);
        pend_next     = (state == MEMWAIT || mem_stall) && (pend || BranchTakenE);
        wait_cnt_next = (state == MEMWAIT) ? (&wait_cnt ? wait_cnt : wait_cnt + 1'b1)
                      : (mem_stall ? WAIT_CNT_W'(1) : wait_cnt);
    end

    always_comb begin
        EnF        = 1'b1;
        d.en       = 1'b1;
        d.clear    = 1'b0;
        e.en       = 1'b1;
        e.clear    = 1'b0;
        EnM        = 1'b1;
        ClearW     = 1'b0;
        RedirectOK = 1'b0;
        if (state == INIT) begin
            EnF     = 1'b0;
            d.clear = 1'b1;
            e.clear = 1'b1;
            ClearW  = 1'b1;
        end else if (mem_stall) begin
            EnF    = 1'b0;
            d.en   = 1'b0;
            e.en   = 1'b0;
            EnM    = 1'b0;
            ClearW = 1'b1;
        end else if (state == RUN && (BranchTakenE || pend)) begin
            RedirectOK = 1'b1;
            d.clear    = 1'b1;
            e.clear    = 1'b1;
        end else if (state == RUN && JumpD) begin
            RedirectOK = 1'b1;
            d.clear    = 1'b1;
        end else if (state == RUN && load_use) begin
            EnF     = 1'b0;
            d.en    = 1'b0;
            e.clear = 1'b1;
        end else if (state == RUN && !ImemReadyF) begin
            EnF     = 1'b0;
            d.clear = 1'b1;
        end
    end

    assign EnD    = d.en;
    assign ClearD = d.clear;
    assign EnE    = e.en;
    assign ClearE = e.clear;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (state != INIT) begin
            stall_q <= stall_q + {31'd0, !EnF};
            flush_q <= flush_q + {31'd0, d.clear || e.clear};
        end
    end
    assign StallCycles = stall_q;
    assign FlushCount  = flush_q;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed plus randomized checks of pipe_ctrl against a rule-level model
module tb_pipe_ctrl;
    localparam int TO = 4;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic        MemReadE, JumpD, BranchTakenE, ImemReadyF, DmemReqM, DmemReadyM;
    logic        EnF, EnD, ClearD, EnE, ClearE, EnM, ClearW, RedirectOK, MemTimeout;
    logic [31:0] StallCycles, FlushCount;
    logic [7:0]  outs;
    int          n_vec = 0, n_bad = 0;
    bit          m_init, m_wait, m_pend, m_to;
    int          m_cnt;
    logic [31:0] m_stall, m_flush;

    pipe_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .MemReadE(MemReadE),
        .JumpD(JumpD), .BranchTakenE(BranchTakenE), .ImemReadyF(ImemReadyF),
        .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM), .EnF(EnF), .EnD(EnD), .ClearD(ClearD),
        .EnE(EnE), .ClearE(ClearE), .EnM(EnM), .ClearW(ClearW), .RedirectOK(RedirectOK),
        .MemTimeout(MemTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;
    assign outs = {EnF, EnD, ClearD, EnE, ClearE, EnM, ClearW, RedirectOK};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {EnF,EnD,ClearD,EnE,ClearE,EnM,ClearW,RedirectOK} straight from the priority rules
    function automatic logic [7:0] model_out();
        bit lu = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
        if (m_init) return 8'b0111_1110;
        if (m_wait ? !DmemReadyM : (DmemReqM && !DmemReadyM)) return 8'b0000_0010;
        if (m_wait) return 8'b1101_0100;
        if (BranchTakenE || m_pend) return 8'b1111_1101;
        if (JumpD) return 8'b1111_0101;
        if (lu) return 8'b0001_1100;
        if (!ImemReadyF) return 8'b0111_0100;
        return 8'b1101_0100;
    endfunction

    task automatic check_counters();
`ifdef PIPE_CTRL_PERF_EN
        check("stall_cnt", StallCycles, m_stall);
        check("flush_cnt", FlushCount, m_flush);
`else
        check("stall_cnt", StallCycles, 32'd0);
        check("flush_cnt", FlushCount, 32'd0);
`endif
    endtask

    task automatic step();
        logic [7:0] e;
        #2;
        e = model_out();
        check("ctrl", {24'd0, outs}, {24'd0, e});
        check("timeout", {31'd0, MemTimeout}, {31'd0, m_to || (m_wait && m_cnt == TO)});
        check_counters();
        @(posedge clk);
        if (m_init) m_init = 0;
        else begin
            m_stall += {31'd0, !e[7]};
            m_flush += {31'd0, e[5] | e[3]};
            if (m_wait) begin
                if (m_cnt == TO) m_to = 1;
                m_pend |= BranchTakenE;
                if (DmemReadyM) m_wait = 0;
                else if (m_cnt < 255) m_cnt++;
            end else if (DmemReqM && !DmemReadyM) begin
                m_wait = 1;
                m_cnt  = 1;
                m_pend |= BranchTakenE;
            end else m_pend = 0;
        end
        #1;
    endtask

    task automatic idle();
        {Rs1D, Rs2D, RdE} = '0;
        {MemReadE, JumpD, BranchTakenE, DmemReqM, DmemReadyM} = '0;
        ImemReadyF = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", {24'd0, outs}, 32'h7E);
        check("rst_timeout", {31'd0, MemTimeout}, 32'd0);
        check("rst_stall", StallCycles, 32'd0);
        check("rst_flush", FlushCount, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        {m_wait, m_pend, m_to} = '0;
        m_init  = 1;
        m_cnt   = 0;
        m_stall = '0;
        m_flush = '0;
    endtask

    initial begin
        idle();
        #1;
        do_reset();
        #1 check("init_ctrl", {24'd0, outs}, 32'h7E);
        step();
        #1 check("run_ctrl", {24'd0, outs}, 32'hD4);
        step();
        MemReadE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
        #1 check("load_use", {24'd0, outs}, 32'h1C);
        step();
        RdE = 5'd0; Rs2D = 5'd0;
        #1 check("x0_no_stall", {24'd0, outs}, 32'hD4);
        step();
        idle();
        BranchTakenE = 1'b1; JumpD = 1'b1;
        #1 check("branch_wins", {24'd0, outs}, 32'hFD);
        step();
        idle();
        step();
        DmemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            BranchTakenE = (i == 1);
            #1 check("memwait", {24'd0, outs}, 32'h02);
            step();
        end
        BranchTakenE = 1'b0; DmemReadyM = 1'b1;
        #1 check("mem_ready", {24'd0, outs}, 32'hD4);
        step();
        idle();
        #1 check("deferred_redirect", {24'd0, outs}, 32'hFD);
        step();
        step();
        do_reset();
        step();
        DmemReqM = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("timeout_sticky", {31'd0, MemTimeout}, 32'd1);
        DmemReadyM = 1'b1;
        step();
        idle();
        step();
        do_reset();
        step();
        for (int i = 0; i < 2; i++) begin
            MemReadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
            step();
            idle();
            step();
        end
        BranchTakenE = 1'b1;
        step();
        idle();
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall", StallCycles, 32'd2);
        check("perf_flush", FlushCount, 32'd3);
`else
        check("perf_stall", StallCycles, 32'd0);
        check("perf_flush", FlushCount, 32'd0);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            Rs1D         = 5'($urandom_range(0, 3));
            Rs2D         = 5'($urandom_range(0, 3));
            RdE          = 5'($urandom_range(0, 3));
            MemReadE     = ($urandom_range(0, 2) == 0);
            JumpD        = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            ImemReadyF   = ($urandom_range(0, 3) != 0);
            DmemReqM     = ($urandom_range(0, 3) == 0);
            DmemReadyM   = ($urandom_range(0, 2) == 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and sequencing controller for the five-stage RV32 core. Drives the enable/clear pairs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable from load-use hazards, control-flow redirects and instruction/data memory wait handshakes. It defers redirects that arrive during a memory stall and watchdogs stuck data-memory accesses. Sits beside the datapath at the top of the core; every pipeline register's `en`/`clear` comes from here.

## Interface
- `TIMEOUT_CYCLES`, default 255: data-memory wait cycles before `MemTimeout` fires; range 1..255 (8-bit counter).
- `clk  in  1`: core clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `Rs1D`, `Rs2D  in  5 each`: source registers of the instruction in ID.
- `RdE  in  5`: destination of the instruction in EX.
- `MemReadE  in  1`: EX instruction is a load.
- `JumpD  in  1`: JAL resolved in ID, PC redirect this cycle.
- `BranchTakenE  in  1`: taken branch or JALR resolved in EX.
- `ImemReadyF  in  1`: instruction word valid at IF this cycle.
- `DmemReqM  in  1`: MEM stage has an outstanding load/store.
- `DmemReadyM  in  1`: data memory completes the access this cycle.
- `EnF  out  1`: PC register enable.
- `EnD`, `ClearD  out  1 each`: IF/ID register enable and clear.
- `EnE`, `ClearE  out  1 each`: ID/EX register enable and clear.
- `EnM  out  1`: EX/MEM register enable.
- `ClearW  out  1`: MEM/WB clear, inserts a WB bubble.
- `RedirectOK  out  1`: PC mux may take the redirect target this cycle.
- `MemTimeout  out  1`: sticky watchdog error.
- `StallCycles`, `FlushCount  out  32 each`: performance counters (see Configuration).

## Operation
- States: INIT, RUN, MEMWAIT. Registered state also includes `pend_redirect` (1 bit) and `wait_cnt` (8 bits).
- INIT lasts one cycle after reset release. In INIT: `EnF=0`, `EnD=EnE=EnM=1`, `ClearD=ClearE=ClearW=1`, `RedirectOK=0`. INIT always moves to RUN.
- RUN priority, highest first:
  1. Memory wait. Condition: `DmemReqM && !DmemReadyM`. Outputs: `EnF=EnD=EnE=EnM=0`, `ClearW=1`, `ClearD=ClearE=0`. Next state MEMWAIT, `wait_cnt` loads 1, and `pend_redirect` is set if `BranchTakenE` is high.
  2. Redirect. Condition: `BranchTakenE` or `pend_redirect`. Outputs: `EnF=1`, `RedirectOK=1`, `ClearD=ClearE=1`, all enables 1. Clears `pend_redirect`.
  3. `JumpD`. Outputs: `EnF=1`, `RedirectOK=1`, `ClearD=1`, `ClearE=0`.
  4. Load-use. Condition: `MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)`. Outputs: `EnF=0`, `EnD=0`, `EnE=1`, `ClearE=1`.
  5. Fetch wait. Condition: `!ImemReadyF`. Outputs: `EnF=0`, `EnD=1`, `ClearD=1`.
  6. Otherwise all enables are 1 and all clears are 0.
- MEMWAIT:
  - Holds the memory-wait outputs.
  - `wait_cnt` increments each cycle and saturates at 255.
  - `BranchTakenE` seen here sets `pend_redirect`.
  - On `DmemReadyM`, returns to RUN with the same outputs as RUN case 6. `pend_redirect` is then serviced on the next cycle as RUN case 2.
  - When `wait_cnt == TIMEOUT_CYCLES`, `MemTimeout` is set and stays set until reset. The controller stays in MEMWAIT.
- Invariants:
  - `ClearD` is never high while `EnD=0`, because IF/ID ignores clear when disabled. The same rule applies to `ClearE` with `EnE`.
  - Register x0 never causes a load-use stall.

## Timing
- All outputs are combinational from registered state plus current inputs, so decision latency is 0 cycles.
- State, `pend_redirect`, `wait_cnt` and counters update on `posedge clk`.
- Output values while `rst_n=0` (the INIT values): `EnF=0`, `EnD=EnE=EnM=1`, `ClearD=ClearE=ClearW=1`, `RedirectOK=0`, `MemTimeout=0`, counters 0.
- Reset asserted mid-MEMWAIT drops any pending redirect and clears the watchdog.
- Load-use inserts exactly 1 bubble.
- A taken branch costs 2 bubbles. JAL costs 1 bubble.
- A redirect that arrives during MEMWAIT is applied in the first cycle after `DmemReadyM`.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `StallCycles` increments in every cycle where `EnF=0`, excluding INIT.
  - `FlushCount` increments in every cycle where `ClearD` or `ClearE` is high, excluding INIT.
  - Both counters wrap at 2^32.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Structure
- `pipe_ctrl_pkg` holds the `pipe_state_t` enum (INIT, RUN, MEMWAIT), the `WAIT_CNT_W=8` constant, and the `stage_ctrl_t` struct (`en`, `clear`).
- Sub-module `load_use_detect`: purely combinational comparator producing the load-use hazard bit.

## Test plan
- Reset release, all inputs benign → INIT for 1 cycle with all clears 1, then RUN with all enables 1 and `EnF=1`.
- `MemReadE=1`, `RdE=5`, `Rs2D=5` → `EnF=0`, `EnD=0`, `ClearE=1` for 1 cycle. Repeat with `RdE=0` → no stall.
- `BranchTakenE=1` together with `JumpD=1` → `ClearD=ClearE=1`, `RedirectOK=1`, so the branch wins.
- `DmemReqM=1` with `DmemReadyM` low for 3 cycles, `BranchTakenE` pulsed in the 2nd → enables 0 and `ClearW=1` for 3 cycles, then the redirect flush occurs 1 cycle after ready.
- `TIMEOUT_CYCLES=4`, ready never asserted → `MemTimeout` rises on the 4th MEMWAIT cycle and stays high. `rst_n` pulse clears it.
- `PIPE_CTRL_PERF_EN` defined, 2 load-use stalls plus 1 taken branch → `StallCycles=2`, `FlushCount=3`. Built without the macro → both read 0.
